mem_rd_master: RTL and testbench

MEM_RD_MASTER -- requirements
Module: mem_rd_master

---
 rtl/mem_rd_master.sv | 99 +++++++++
 tb/tb_mem_rd_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_rd_master.sv
// mem_rd_master: single-outstanding load master with extraction, sign extension and read timeout
module mem_rd_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [31:0] araddr_o,
  input  logic        rvalid_i,
  output logic        rready_o,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i
);
  typedef enum logic [2:0] {IDLE, AR, R, RESP, DRAIN} state_t;
  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [15:0] cnt;
  logic        drain_q;
  logic        mis;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ext;
  always_comb begin
    mis = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
          (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    b   = rdata_i[{off_q, 3'b000} +: 8];
    h   = rdata_i[{off_q[1], 4'b0000} +: 16];
    ext = size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b} :
          size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : rdata_i;
  end
  assign req_ready_o  = state == IDLE;
  assign arvalid_o    = state == AR;
  assign rready_o     = state == R || state == DRAIN;
  assign resp_valid_o = state == RESP;
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      cnt         <= '0;
      drain_q     <= 1'b0;
      araddr_o    <= '0;
      resp_data_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          off_q  <= req_addr_i[1:0];
          size_q <= req_size_i;
          uns_q  <= req_unsigned_i;
          if (mis) begin
            state       <= RESP;
            resp_err_o  <= 1'b1;
            resp_data_o <= '0;
          end else begin
            state    <= AR;
            araddr_o <= {req_addr_i[31:2], 2'b00};
          end
        end
        AR: if (arready_i) begin
          state <= R;
          cnt   <= '0;
        end
        // rvalid_i takes priority over the terminal count
        R: if (rvalid_i) begin
          state       <= RESP;
          resp_err_o  <= rresp_i != 2'b00;
          resp_data_o <= rresp_i != 2'b00 ? 32'd0 : ext;
        end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state       <= RESP;
          resp_err_o  <= 1'b1;
          resp_data_o <= '0;
          drain_q     <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        RESP: if (resp_ready_i) state <= drain_q ? DRAIN : IDLE;
        DRAIN: if (rvalid_i) begin
          drain_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rd_master.sv
// tb_mem_rd_master: directed and randomized loads checked against a behavioural load model
module tb_mem_rd_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        arvalid_o;
  logic        arready_i = 1'b0;
  logic [31:0] araddr_o;
  logic        rvalid_i = 1'b0;
  logic        rready_o;
  logic [31:0] rdata_i = '0;
  logic [1:0]  rresp_i = '0;
  int n_cmp = 0;
  int n_err = 0;
  localparam int TO = 4;
  mem_rd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  function automatic bit model_bad(input logic [31:0] a, input logic [1:0] sz);
    return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction
  function automatic logic [31:0] model_data(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * (a % 4));
    if (sz == 2'd0) return u ? (s & 32'hFF) : 32'($signed(s[7:0]));
    if (sz == 2'd1) return u ? (s & 32'hFFFF) : 32'($signed(s[15:0]));
    return rd;
  endfunction
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input int ar_w, input int r_w, input int rsp_w,
                         input logic [31:0] rd, input logic [1:0] rr, input bit to, input int dr_w);
    bit bad;
    bit err;
    logic [31:0] exp_d;
    bad   = model_bad(a, sz);
    err   = bad || to || rr != 2'd0;
    exp_d = err ? 32'd0 : model_data(a, sz, u, rd);
    chk("idle_ready", req_ready_o, 1);
    req_valid_i = 1'b1; req_addr_i = a; req_size_i = sz; req_unsigned_i = u;
    step();
    req_valid_i = 1'b0; req_addr_i = $urandom; req_size_i = 2'($urandom);
    if (!bad) begin
      for (int i = 0; i <= ar_w; i++) begin
        chk("arvalid", arvalid_o, 1);
        chk("araddr", araddr_o, a & 32'hFFFF_FFFC);
        chk("ar_ready_low", req_ready_o, 0);
        chk("ar_rready", rready_o, 0);
        arready_i = i == ar_w;
        step();
      end
      arready_i = 1'b0;
      if (to) begin
        for (int i = 0; i < TO; i++) begin
          chk("r_rready_to", rready_o, 1);
          chk("r_no_resp_to", resp_valid_o, 0);
          step();
        end
      end else begin
        for (int i = 0; i <= r_w; i++) begin
          chk("r_rready", rready_o, 1);
          chk("r_arvalid", arvalid_o, 0);
          chk("r_no_resp", resp_valid_o, 0);
          rvalid_i = i == r_w;
          rdata_i  = i == r_w ? rd : 32'($urandom);
          rresp_i  = i == r_w ? rr : 2'($urandom);
          step();
        end
        rvalid_i = 1'b0; rdata_i = $urandom; rresp_i = 2'($urandom);
      end
    end
    for (int i = 0; i <= rsp_w; i++) begin
      chk("resp_valid", resp_valid_o, 1);
      chk("resp_data", resp_data_o, exp_d);
      chk("resp_err", resp_err_o, 32'(err));
      chk("resp_arvalid", arvalid_o, 0);
      chk("resp_ready_low", req_ready_o, 0);
      resp_ready_i = i == rsp_w;
      step();
    end
    resp_ready_i = 1'b0;
    if (to && !bad) begin
      for (int i = 0; i <= dr_w; i++) begin
        chk("drain_rready", rready_o, 1);
        chk("drain_ready_low", req_ready_o, 0);
        chk("drain_no_resp", resp_valid_o, 0);
        rvalid_i = i == dr_w;
        step();
      end
      rvalid_i = 1'b0;
    end
    chk("back_idle", req_ready_o, 1);
    chk("idle_rready", rready_o, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_araddr", araddr_o, 0);
    chk("rst_data", resp_data_o, 0);
    chk("rst_err", resp_err_o, 0);
    reset = 1'b0;
    step();
    do_load(32'h0200_BFF8, 2'd2, 1'b0, 0, 0, 0, 32'h1234_5678, 2'd0, 0, 0);
    do_load(32'h8000_0003, 2'd0, 1'b0, 0, 0, 0, 32'h80FF_0000, 2'd0, 0, 0);
    do_load(32'h8000_0003, 2'd0, 1'b1, 0, 0, 0, 32'h80FF_0000, 2'd0, 0, 0);
    do_load(32'h8000_0002, 2'd1, 1'b0, 0, 0, 0, 32'h80FF_0000, 2'd0, 0, 0);
    do_load(32'h8000_0001, 2'd1, 1'b0, 0, 0, 0, 32'h0, 2'd0, 0, 0);
    do_load(32'h8000_0000, 2'd3, 1'b0, 0, 0, 0, 32'h0, 2'd0, 0, 0);
    do_load(32'h1000_0004, 2'd2, 1'b0, 5, 3, 4, 32'hCAFE_F00D, 2'd0, 0, 0);
    do_load(32'h1000_0008, 2'd2, 1'b0, 1, 0, 1, 32'h0, 2'd0, 1, 7);
    do_load(32'h1000_000C, 2'd2, 1'b0, 0, 1, 0, 32'hDEAD_BEEF, 2'd2, 0, 0);
    req_valid_i = 1'b1; req_addr_i = 32'h2000_0000; req_size_i = 2'd2;
    step();
    req_valid_i = 1'b0;
    arready_i = 1'b1;
    step();
    arready_i = 1'b0;
    chk("pre_rst_rready", rready_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_req_ready", req_ready_o, 1);
    chk("mid_rst_rready", rready_o, 0);
    chk("mid_rst_arvalid", arvalid_o, 0);
    chk("mid_rst_resp_valid", resp_valid_o, 0);
    chk("mid_rst_araddr", araddr_o, 0);
    chk("mid_rst_data", resp_data_o, 0);
    chk("mid_rst_err", resp_err_o, 0);
    do_load(32'h3000_0002, 2'd1, 1'b1, 0, 0, 0, 32'hA5A5_8001, 2'd0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = sz == 2'd2 ? a & ~32'h3 : sz == 2'd1 ? a & ~32'h1 : a;
      do_load(a, sz, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, TO - 1),
              $urandom_range(0, 3), $urandom,
              $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 8));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
